// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample/bus widths, saturation limits and the
// packet FSM state encoding used by the AXIS volume stage.
package audio_pkg;

   localparam int SAMPLE_W = 24;
   localparam int AXIS_W   = 32;

   localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = 24'h7FFFFF;
   localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = 24'h800000;

   typedef enum logic [2:0] {
      RX_L,
      RX_R,
      CALC,
      TX_L,
      TX_R
   } state_t;

endpackage

// File: rtl/gain_sat.sv
// Combinational gain stage: signed sample times unsigned gain code, arithmetic
// shift by VOL_W-1 (unity at code 2^(VOL_W-1)), then clamp to sample range.
module gain_sat #(
   parameter int SAMPLE_W = 24,
   parameter int VOL_W    = 4
) (
   input  logic [SAMPLE_W-1:0] x_i,
   input  logic [VOL_W-1:0]    gain_i,
   output logic [SAMPLE_W-1:0] y_o
);

   localparam int PROD_W = SAMPLE_W + VOL_W + 1;

   logic signed [PROD_W-1:0] x_ext;
   logic signed [PROD_W-1:0] g_ext;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] shifted;
   logic signed [PROD_W-1:0] lim_hi;
   logic signed [PROD_W-1:0] lim_lo;

   // Multiply at full width so the product never wraps, shift, then saturate
   always_comb begin
      x_ext   = {{(VOL_W + 1){x_i[SAMPLE_W-1]}}, x_i};
      g_ext   = {{(SAMPLE_W + 1){1'b0}}, gain_i};
      prod    = x_ext * g_ext;
      shifted = prod >>> (VOL_W - 1);

      lim_hi                 = '0;
      lim_hi[SAMPLE_W-2:0]   = '1;
      lim_lo                 = '1;
      lim_lo[SAMPLE_W-2:0]   = '0;

      if (shifted > lim_hi) begin
         y_o = lim_hi[SAMPLE_W-1:0];
      end else if (shifted < lim_lo) begin
         y_o = lim_lo[SAMPLE_W-1:0];
      end else begin
         y_o = shifted[SAMPLE_W-1:0];
      end
   end

endmodule

// File: rtl/axis_volume.sv
// AXIS stereo volume stage: buffers one L/R packet, applies a latched gain
// with saturation (or mute) to both channels, and replays it back-to-back.
module axis_volume #(
   parameter int VOL_W    = 4,
   parameter int SAMPLE_W = 24
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [VOL_W-1:0] i_vol,
   input  logic             i_mute,
   input  logic [31:0]      axis_s_data,
   input  logic             axis_s_vld,
   output logic             axis_s_rdy,
   input  logic             axis_s_last,
   output logic [31:0]      axis_m_data,
   output logic             axis_m_vld,
   input  logic             axis_m_rdy,
   output logic             axis_m_last
);

   import audio_pkg::*;

   state_t               state_q, state_d;
   logic [VOL_W-1:0]     vol_s1_q, vol_s2_q, gain_q;
   logic                 mute_s1_q, mute_s2_q, mute_q;
   logic [SAMPLE_W-1:0]  l_q, r_q, yr_q;
   logic [SAMPLE_W-1:0]  yl_w, yr_w, yl_sel, yr_sel;
   logic                 s_rdy_q, m_vld_q, m_last_q;
   logic [AXIS_W-1:0]    m_data_q;
   logic                 s_hs;
   logic                 unused_s_hi;

   assign s_hs        = axis_s_vld & s_rdy_q;
   assign unused_s_hi = ^axis_s_data[AXIS_W-1:SAMPLE_W];

   gain_sat #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W)) u_gain_l (
      .x_i    (l_q),
      .gain_i (gain_q),
      .y_o    (yl_w)
   );

   gain_sat #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W)) u_gain_r (
      .x_i    (r_q),
      .gain_i (gain_q),
      .y_o    (yr_w)
   );

   assign yl_sel = mute_q ? '0 : yl_w;
   assign yr_sel = mute_q ? '0 : yr_w;

   // Packet sequencing: receive L, receive R, compute, send L, send R
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_L:    if (s_hs && !axis_s_last) state_d = RX_R;
         RX_R:    if (s_hs && axis_s_last)  state_d = CALC;
         CALC:    state_d = TX_L;
         TX_L:    if (axis_m_rdy) state_d = TX_R;
         TX_R:    if (axis_m_rdy) state_d = RX_L;
         default: state_d = RX_L;
      endcase
   end

   // State, synchronisers, sample capture and registered AXIS outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= RX_L;
         vol_s1_q  <= '0;
         vol_s2_q  <= '0;
         mute_s1_q <= 1'b0;
         mute_s2_q <= 1'b0;
         gain_q    <= '0;
         mute_q    <= 1'b0;
         l_q       <= '0;
         r_q       <= '0;
         yr_q      <= '0;
         s_rdy_q   <= 1'b0;
         m_vld_q   <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= '0;
      end else begin
         vol_s1_q  <= i_vol;
         vol_s2_q  <= vol_s1_q;
         mute_s1_q <= i_mute;
         mute_s2_q <= mute_s1_q;

         state_q   <= state_d;
         s_rdy_q   <= (state_d == RX_L) || (state_d == RX_R);
         m_vld_q   <= (state_d == TX_L) || (state_d == TX_R);
         m_last_q  <= (state_d == TX_R);

         unique case (state_q)
            RX_L: begin
               if (s_hs && !axis_s_last) begin
                  l_q    <= axis_s_data[SAMPLE_W-1:0];
                  gain_q <= vol_s2_q;
                  mute_q <= mute_s2_q;
               end
            end
            RX_R: begin
               if (s_hs) begin
                  if (axis_s_last) begin
                     r_q <= axis_s_data[SAMPLE_W-1:0];
                  end else begin
                     // A second left word restarts the packet on the newest L
                     l_q    <= axis_s_data[SAMPLE_W-1:0];
                     gain_q <= vol_s2_q;
                     mute_q <= mute_s2_q;
                  end
               end
            end
            CALC: begin
               yr_q     <= yr_sel;
               m_data_q <= {{(AXIS_W - SAMPLE_W){1'b0}}, yl_sel};
            end
            TX_L: begin
               if (axis_m_rdy) m_data_q <= {{(AXIS_W - SAMPLE_W){1'b0}}, yr_q};
            end
            default: ;
         endcase
      end
   end

   assign axis_s_rdy  = s_rdy_q;
   assign axis_m_vld  = m_vld_q;
   assign axis_m_last = m_last_q;
   assign axis_m_data = m_data_q;

endmodule

// File: tb/tb_axis_volume.sv
// Self-checking bench for axis_volume: directed scenarios plus randomized
// packets checked against an arithmetic reference of the gain/saturate rule.
module tb_axis_volume;

   localparam int VOL_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [VOL_W-1:0] vol;
   logic             mute;
   logic [31:0]      s_data;
   logic             s_vld;
   logic             s_rdy;
   logic             s_last;
   logic [31:0]      m_data;
   logic             m_vld;
   logic             m_rdy;
   logic             m_last;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   hs_cyc = 0;
   bit   rand_rdy = 1'b0;
   logic [32:0] outq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_volume #(.VOL_W(VOL_W), .SAMPLE_W(24)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_vol       (vol),
      .i_mute      (mute),
      .axis_s_data (s_data),
      .axis_s_vld  (s_vld),
      .axis_s_rdy  (s_rdy),
      .axis_s_last (s_last),
      .axis_m_data (m_data),
      .axis_m_vld  (m_vld),
      .axis_m_rdy  (m_rdy),
      .axis_m_last (m_last)
   );

   // Output monitor: every accepted output word, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && m_vld && m_rdy) outq.push_back({m_last, m_data});
   end

   // Random downstream backpressure when enabled
   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         m_rdy = 1'($urandom_range(0, 1));
      end
   end

   // Reference: y = floor(x * g / 2^(VOL_W-1)), clamped to 24-bit signed, 0 if muted
   function automatic logic [31:0] ref_out(input logic [23:0] x, input int g, input bit m);
      longint xs, p, y, scale;
      scale = longint'(1) << (VOL_W - 1);
      xs = longint'($signed(x));
      p  = xs * longint'(g);
      if (p >= 0) y = p / scale;
      else        y = -((-p + scale - 1) / scale);
      if (y > 8388607)  y = 8388607;
      if (y < -8388608) y = -8388608;
      if (m) y = 0;
      return {8'h00, y[23:0]};
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ctl(input int v, input bit m);
      vol  = VOL_W'(v);
      mute = m;
      step(3);
   endtask

   // Present one input beat and hold it until accepted (bounded)
   task automatic beat(input logic [31:0] d, input bit l);
      bit ok;
      s_data = d;
      s_last = l;
      s_vld  = 1'b1;
      for (int n = 0; ; n++) begin
         @(negedge clk);
         ok = s_rdy;
         @(posedge clk);
         #1;
         if (ok) begin
            hs_cyc = cyc;
            break;
         end
         if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL s_handshake_timeout actual s_rdy=0 required 1");
            break;
         end
      end
      s_vld = 1'b0;
   endtask

   // Wait (bounded) for two output words and return them
   task automatic pop_pkt(output bit ok, output logic [32:0] a, output logic [32:0] b);
      ok = 1'b0;
      a  = '0;
      b  = '0;
      for (int n = 0; n < 400; n++) begin
         if (outq.size() >= 2) begin
            ok = 1'b1;
            break;
         end
         step(1);
      end
      if (ok) begin
         a = outq.pop_front();
         b = outq.pop_front();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; s_vld = 1'b0; s_last = 1'b0; s_data = '0;
      m_rdy = 1'b0; vol = '0; mute = 1'b0;
      step(3);
      @(negedge clk);
      n_cmp++; if (s_rdy !== 1'b0)   begin n_bad++; $display("FAIL reset_s_rdy actual %b required 0", s_rdy); end
      n_cmp++; if (m_vld !== 1'b0)   begin n_bad++; $display("FAIL reset_m_vld actual %b required 0", m_vld); end
      n_cmp++; if (m_last !== 1'b0)  begin n_bad++; $display("FAIL reset_m_last actual %b required 0", m_last); end
      n_cmp++; if (m_data !== 32'h0) begin n_bad++; $display("FAIL reset_m_data actual %h required 0", m_data); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++; if (s_rdy !== 1'b1)   begin n_bad++; $display("FAIL post_reset_s_rdy actual %b required 1", s_rdy); end
      n_cmp++; if (m_vld !== 1'b0)   begin n_bad++; $display("FAIL post_reset_m_vld actual %b required 0", m_vld); end
      @(posedge clk); #1;
   endtask

   task automatic test_unity();
      bit ok; logic [32:0] a, b;
      m_rdy = 1'b1;
      set_ctl(8, 0);
      beat(32'h0010_0000, 1'b0);
      beat(32'h00F0_0000, 1'b1);
      @(negedge clk);
      n_cmp++; if (m_vld !== 1'b0) begin n_bad++; $display("FAIL latency_early actual m_vld=%b required 0", m_vld); end
      @(negedge clk);
      n_cmp++; if (m_vld !== 1'b1) begin n_bad++; $display("FAIL latency_n2 actual m_vld=%b required 1", m_vld); end
      @(posedge clk); #1;
      pop_pkt(ok, a, b);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL unity_timeout actual %0d words required 2", outq.size()); end
      n_cmp++; if (a !== {1'b0, ref_out(24'h100000, 8, 0)}) begin n_bad++; $display("FAIL unity_L actual %h required %h", a, {1'b0, ref_out(24'h100000, 8, 0)}); end
      n_cmp++; if (b !== {1'b1, ref_out(24'hF00000, 8, 0)}) begin n_bad++; $display("FAIL unity_R actual %h required %h", b, {1'b1, ref_out(24'hF00000, 8, 0)}); end
   endtask

   task automatic test_attenuation();
      bit ok; logic [32:0] a, b; logic [23:0] l, r;
      m_rdy = 1'b1;
      set_ctl(4, 0);
      beat(32'h0010_0000, 1'b0);
      beat(32'h00FF_FFFF, 1'b1);
      pop_pkt(ok, a, b);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL atten_timeout actual %0d words required 2", outq.size()); end
      n_cmp++; if (a !== {1'b0, ref_out(24'h100000, 4, 0)}) begin n_bad++; $display("FAIL atten_L actual %h required %h", a, {1'b0, ref_out(24'h100000, 4, 0)}); end
      n_cmp++; if (b !== {1'b1, ref_out(24'hFFFFFF, 4, 0)}) begin n_bad++; $display("FAIL atten_R_floor actual %h required %h", b, {1'b1, ref_out(24'hFFFFFF, 4, 0)}); end
      set_ctl(0, 0);
      l = 24'($urandom); r = 24'($urandom);
      beat({8'h00, l}, 1'b0);
      beat({8'h00, r}, 1'b1);
      pop_pkt(ok, a, b);
      n_cmp++; if (a !== {1'b0, 32'h0}) begin n_bad++; $display("FAIL vol0_L actual %h required %h", a, {1'b0, 32'h0}); end
      n_cmp++; if (b !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL vol0_R actual %h required %h", b, {1'b1, 32'h0}); end
   endtask

   task automatic test_saturation();
      bit ok; logic [32:0] a, b;
      m_rdy = 1'b1;
      for (int m = 0; m < 2; m++) begin
         set_ctl(15, m[0]);
         beat(32'h0060_0000, 1'b0);
         beat(32'h00A0_0000, 1'b1);
         pop_pkt(ok, a, b);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL sat_timeout mute=%0d actual %0d words required 2", m, outq.size()); end
         n_cmp++; if (a !== {1'b0, ref_out(24'h600000, 15, m[0])}) begin n_bad++; $display("FAIL sat_L mute=%0d actual %h required %h", m, a, {1'b0, ref_out(24'h600000, 15, m[0])}); end
         n_cmp++; if (b !== {1'b1, ref_out(24'hA00000, 15, m[0])}) begin n_bad++; $display("FAIL sat_R mute=%0d actual %h required %h", m, b, {1'b1, ref_out(24'hA00000, 15, m[0])}); end
      end
   endtask

   task automatic test_backpressure();
      bit ok; logic [32:0] a, b; logic [23:0] l, r; logic [31:0] cap_d; logic cap_l;
      int bad_stable;
      m_rdy = 1'b0;
      set_ctl(8, 0);
      l = 24'($urandom); r = 24'($urandom);
      beat({8'h5A, l}, 1'b0);
      beat({8'hA5, r}, 1'b1);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (m_vld) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_vld_timeout actual m_vld=0 required 1"); end
      cap_d = m_data; cap_l = m_last;
      n_cmp++; if ({cap_l, cap_d} !== {1'b0, ref_out(l, 8, 0)}) begin n_bad++; $display("FAIL bp_first_word actual %h required %h", {cap_l, cap_d}, {1'b0, ref_out(l, 8, 0)}); end
      bad_stable = 0;
      repeat (50) begin
         @(negedge clk);
         n_cmp++;
         if (m_vld !== 1'b1 || m_data !== cap_d || m_last !== cap_l || s_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold actual vld=%b data=%h last=%b s_rdy=%b required vld=1 data=%h last=%b s_rdy=0",
                     m_vld, m_data, m_last, s_rdy, cap_d, cap_l);
         end
      end
      @(posedge clk); #1;
      m_rdy = 1'b1;
      pop_pkt(ok, a, b);
      n_cmp++; if (a !== {1'b0, ref_out(l, 8, 0)}) begin n_bad++; $display("FAIL bp_L actual %h required %h", a, {1'b0, ref_out(l, 8, 0)}); end
      n_cmp++; if (b !== {1'b1, ref_out(r, 8, 0)}) begin n_bad++; $display("FAIL bp_R actual %h required %h", b, {1'b1, ref_out(r, 8, 0)}); end
   endtask

   task automatic test_gain_latch();
      bit ok; logic [32:0] a, b; logic [23:0] l, r;
      m_rdy = 1'b1;
      set_ctl(8, 0);
      l = 24'h123456; r = 24'hEDCBA9;
      beat({8'h00, l}, 1'b0);
      vol = 4'd2;
      mute = 1'b1;
      step(5);
      beat({8'h00, r}, 1'b1);
      pop_pkt(ok, a, b);
      n_cmp++; if (a !== {1'b0, ref_out(l, 8, 0)}) begin n_bad++; $display("FAIL latch_L actual %h required %h", a, {1'b0, ref_out(l, 8, 0)}); end
      n_cmp++; if (b !== {1'b1, ref_out(r, 8, 0)}) begin n_bad++; $display("FAIL latch_R actual %h required %h", b, {1'b1, ref_out(r, 8, 0)}); end
   endtask

   task automatic test_framing();
      bit ok; logic [32:0] a, b;
      m_rdy = 1'b1;
      set_ctl(6, 0);
      beat(32'h0033_3333, 1'b1);
      step(20);
      n_cmp++; if (outq.size() != 0) begin n_bad++; $display("FAIL framing_drop actual %0d words required 0", outq.size()); end
      beat(32'h0011_1111, 1'b0);
      beat(32'h0022_2222, 1'b0);
      beat(32'h0044_4444, 1'b1);
      pop_pkt(ok, a, b);
      n_cmp++; if (a !== {1'b0, ref_out(24'h222222, 6, 0)}) begin n_bad++; $display("FAIL framing_L2 actual %h required %h", a, {1'b0, ref_out(24'h222222, 6, 0)}); end
      n_cmp++; if (b !== {1'b1, ref_out(24'h444444, 6, 0)}) begin n_bad++; $display("FAIL framing_R actual %h required %h", b, {1'b1, ref_out(24'h444444, 6, 0)}); end
      step(10);
      n_cmp++; if (outq.size() != 0) begin n_bad++; $display("FAIL framing_extra actual %0d words required 0", outq.size()); end
   endtask

   task automatic test_back_to_back();
      bit ok; logic [32:0] a, b; logic [23:0] l[3], r[3]; int t[3];
      m_rdy = 1'b1;
      set_ctl(11, 0);
      for (int p = 0; p < 3; p++) begin
         l[p] = 24'($urandom); r[p] = 24'($urandom);
         beat({8'h00, l[p]}, 1'b0);
         t[p] = hs_cyc;
         beat({8'h00, r[p]}, 1'b1);
      end
      for (int p = 0; p < 3; p++) begin
         pop_pkt(ok, a, b);
         n_cmp++; if (a !== {1'b0, ref_out(l[p], 11, 0)}) begin n_bad++; $display("FAIL b2b_L%0d actual %h required %h", p, a, {1'b0, ref_out(l[p], 11, 0)}); end
         n_cmp++; if (b !== {1'b1, ref_out(r[p], 11, 0)}) begin n_bad++; $display("FAIL b2b_R%0d actual %h required %h", p, b, {1'b1, ref_out(r[p], 11, 0)}); end
      end
      for (int p = 1; p < 3; p++) begin
         n_cmp++; if (t[p] - t[p-1] != 5) begin n_bad++; $display("FAIL b2b_period actual %0d cycles required 5", t[p] - t[p-1]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok; logic [32:0] a, b;
      m_rdy = 1'b0;
      set_ctl(8, 0);
      beat(32'h0007_0000, 1'b0);
      beat(32'h0009_0000, 1'b1);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (m_vld) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_vld_timeout actual m_vld=0 required 1"); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (m_vld !== 1'b0)  begin n_bad++; $display("FAIL rstmid_m_vld actual %b required 0", m_vld); end
      n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL rstmid_m_last actual %b required 0", m_last); end
      @(negedge clk);
      n_cmp++; if (s_rdy !== 1'b1 || m_vld !== 1'b0) begin n_bad++; $display("FAIL rstmid_rx_l actual s_rdy=%b m_vld=%b required s_rdy=1 m_vld=0", s_rdy, m_vld); end
      @(posedge clk); #1;
      m_rdy = 1'b1;
      step(3);
      n_cmp++; if (outq.size() != 0) begin n_bad++; $display("FAIL rstmid_discard actual %0d words required 0", outq.size()); end
      set_ctl(8, 0);
      beat(32'h0012_3450, 1'b0);
      beat(32'h00FE_DCB0, 1'b1);
      pop_pkt(ok, a, b);
      n_cmp++; if (a !== {1'b0, ref_out(24'h123450, 8, 0)}) begin n_bad++; $display("FAIL rstmid_fresh_L actual %h required %h", a, {1'b0, ref_out(24'h123450, 8, 0)}); end
      n_cmp++; if (b !== {1'b1, ref_out(24'hFEDCB0, 8, 0)}) begin n_bad++; $display("FAIL rstmid_fresh_R actual %h required %h", b, {1'b1, ref_out(24'hFEDCB0, 8, 0)}); end
   endtask

   task automatic test_random();
      bit ok; logic [32:0] a, b; logic [23:0] l, r; int g; bit m;
      rand_rdy = 1'b1;
      for (int p = 0; p < 25; p++) begin
         g = int'($urandom_range(0, 15));
         m = ($urandom_range(0, 5) == 0);
         set_ctl(g, m);
         case ($urandom_range(0, 4))
            0:       begin l = 24'h7FFFFF; r = 24'h800000; end
            1:       begin l = 24'h000001; r = 24'hFFFFF9; end
            default: begin l = 24'($urandom); r = 24'($urandom); end
         endcase
         step(int'($urandom_range(0, 3)));
         beat({8'($urandom), l}, 1'b0);
         step(int'($urandom_range(0, 2)));
         beat({8'($urandom), r}, 1'b1);
         pop_pkt(ok, a, b);
         n_cmp++; if (a !== {1'b0, ref_out(l, g, m)}) begin n_bad++; $display("FAIL rand_L pkt=%0d g=%0d m=%0d actual %h required %h", p, g, m, a, {1'b0, ref_out(l, g, m)}); end
         n_cmp++; if (b !== {1'b1, ref_out(r, g, m)}) begin n_bad++; $display("FAIL rand_R pkt=%0d g=%0d m=%0d actual %h required %h", p, g, m, b, {1'b1, ref_out(r, g, m)}); end
      end
      rand_rdy = 1'b0;
      step(1);
      m_rdy = 1'b1;
   endtask

   initial begin
      test_reset();
      test_unity();
      test_attenuation();
      test_saturation();
      test_backpressure();
      test_gain_latch();
      test_framing();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axis_volume.md
Name: axis_volume

Overview:
- AXIS stage between the I2S transceiver's M port (ADC capture) and its S port (DAC playback).
- Accepts one 2-word stereo packet (left, then right with last=1) and applies a user-selected digital gain with saturation.
- Emits the scaled packet as a 2-word packet in the same format.
- One full packet is buffered, so the downstream sees both words back-to-back and L/R use the same gain.

Parameters:
- VOL_W, 4, width of the volume control input; unity gain code = 2^(VOL_W-1).
- SAMPLE_W, 24, signed audio sample width, right-aligned in the 32-bit AXIS word.

Ports:
- i_clk  in  1  system clock (audio MCLK domain).
- i_rst  in  1  synchronous reset, active-high.
- i_vol  in  VOL_W  gain code from board switches; asynchronous, unsigned.
- i_mute  in  1  forces output samples to zero; asynchronous.
- axis_s_data  in  32  input sample; [23:0] signed two's complement; [31:24] ignored.
- axis_s_vld  in  1  input valid.
- axis_s_rdy  out  1  input ready.
- axis_s_last  in  1  1 = right-channel word (end of packet).
- axis_m_data  out  32  output sample {8'b0, scaled[23:0]}.
- axis_m_vld  out  1  output valid.
- axis_m_rdy  in  1  output ready.
- axis_m_last  out  1  1 on right-channel word.

Behaviour:
- Clock/reset: single clock i_clk. Reset is synchronous, active-high, on i_rst.
- Synchronisation: i_vol and i_mute each pass through a 2-flop synchroniser (reset to 0).
- Reset values:
  - state = RX_L.
  - axis_s_rdy = 0 during reset, 1 on the first cycle after.
  - axis_m_vld = 0, axis_m_last = 0.
  - All data registers = 0.
- FSM states: RX_L, RX_R, CALC, TX_L, TX_R.
- RX_L (s_rdy=1):
  - On handshake with last=0: store L[23:0], latch gain = synced i_vol and mute = synced i_mute, go to RX_R.
  - On handshake with last=1 (framing error): drop the beat and stay in RX_L.
- RX_R (s_rdy=1):
  - On handshake with last=1: store R and go to CALC.
  - On handshake with last=0: overwrite L, re-latch gain/mute, stay in RX_R (resync to the newest left word).
- CALC (s_rdy=0, one cycle):
  - Compute y = (x * gain) >>> (VOL_W-1) for each channel; x is signed SAMPLE_W, gain is unsigned VOL_W, the shift is arithmetic (floor).
  - Product width is SAMPLE_W+VOL_W+1 bits, signed.
  - Saturate y to [-2^23, 2^23-1].
  - mute=1 forces y = 0.
  - Register both results and go to TX_L.
- TX_L:
  - m_vld=1, m_last=0, m_data={8'b0, yL}.
  - On m_rdy, go to TX_R.
- TX_R:
  - m_vld=1, m_last=1, m_data={8'b0, yR}.
  - On m_rdy, go to RX_L.
- Latency: if the R input handshake occurs in cycle N, axis_m_vld is first high in cycle N+2.
- Throughput: one packet per 5 cycles minimum when m_rdy is held high. This is far above the fs requirement (256 clocks per frame).
- Output stability: m_data and m_last are held stable while m_vld=1 and m_rdy=0. m_vld never drops without a handshake.
- Volume changes: changes to i_vol or i_mute mid-packet do not affect the current packet; the value latched at the L beat applies to both channels.
- Reset mid-operation: a partially received or partially sent packet is discarded; the next cycle is in RX_L with m_vld=0.
- s_rdy timing: axis_s_rdy is a registered output, derived from the next state.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W=24, AXIS_W=32.
  - SAMPLE_MAX=24'h7FFFFF, SAMPLE_MIN=24'h800000.
  - The state enum (RX_L, RX_R, CALC, TX_L, TX_R).
- Sub-module gain_sat: combinational signed×unsigned multiply, arithmetic shift and saturate, parameterised by SAMPLE_W and VOL_W. Instantiated twice (L, R); registered in CALC by the parent.

Test Plan:
- Unity gain: vol=8, packet L=0x100000, R=0xF00000, m_rdy=1 -> out L=0x00100000, last=0; then R=0x00F00000, last=1; m_vld first high 2 cycles after the R handshake.
- Attenuation and rounding: vol=4, L=0x100000, R=0xFFFFFF -> L=0x00080000, R=0x00FFFFFF (-1 floors to -1); vol=0 -> both 0.
- Saturation: vol=15, L=0x600000, R=0xA00000 -> L=0x007FFFFF, R=0x00800000; mute=1 with the same input -> both 0x00000000.
- Backpressure and gain latch:
  - Hold m_rdy=0 for 50 cycles -> data/last stable, s_rdy=0 throughout.
  - Change vol from 8 to 2 between the L and R beats -> both channels use gain 8.
- Framing: sequences
  - last=1 beat first -> dropped, no output.
  - L1 (last=0), L2 (last=0), R -> output packet is (L2, R).
- Reset mid-packet: assert i_rst for one cycle during TX_L -> next cycle m_vld=0, state RX_L; a fresh packet then passes correctly.
